operand_fetch: RTL
==================

# operand_fetch

Decode-stage operand reader and hazard controller for the five-stage pipeline. It drives the register file read addresses and selects each source operand from the register file, the E-stage result or the M-stage result. It tracks in-flight destination registers in E, M and W shadow slots and stalls D when a result will not be ready in time. It also holds the D/E operand register and re-forwards E-stage operands from M or W.

## Interface

No parameters.

- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous, active-high reset
- d_valid  in  1  instruction present in D
- d_rs, d_rt  in  5  source register numbers
- d_use_rs, d_use_rt  in  1  source actually read
- d_tuse_rs, d_tuse_rt  in  2  cycles after D until operand consumed (0 = in D, 1 = in E)
- d_dst  in  5  destination register
- d_wen  in  1  instruction writes d_dst
- d_tnew  in  2  cycles after entering E until result forwardable (0 = E, 1 = M, 2 = W)
- rf_a1, rf_a2  out  5  register file read addresses, equal to d_rs and d_rt
- rf_rd1, rf_rd2  in  32  register file read data
- e_fwd_data, m_fwd_data, w_fwd_data  in  32  stage result buses
- stall  out  1  hold D and F, inject bubble into E
- op_rs, op_rt  out  32  forwarded D-stage operands
- e_valid  out  1  D/E register valid
- e_rs_val, e_rt_val  out  32  forwarded E-stage operands
- stall_cnt  out  32  stall cycle counter (see Configuration)

## Operation

- Slots E, M and W each hold {valid, dst, wen, tnew}.
- A slot matches source s when valid & wen & dst==s & s!=0.
- Register 0 never matches, never stalls, and always reads rf data.
- **Stall:** stall = d_valid & (hazard_rs | hazard_rt).
  - hazard_x = use_x & ((E matches x & E.tnew > tuse_x) | (M matches x & M.tnew > tuse_x)).
  - W is never a D-stage hazard.
- **D-stage selection**, youngest first:
  - E match with E.tnew==0 selects e_fwd_data.
  - Otherwise, M match with M.tnew==0 selects m_fwd_data.
  - Otherwise, rf_rd.
  - The register file writes on negedge, so a W-stage write is already visible through rf_rd. No D-stage W bypass exists.
  - A younger not-ready match shadows older matches. A stall covers that case when tuse==0. When tuse==1 the captured value is corrected in E.
- **Slot advance each posedge (not Rst):**
  - W <= M.
  - M <= E, with tnew decremented and saturating at 0.
  - E <= {d_valid, d_dst, d_wen, d_tnew} if !stall, else E <= invalid.
- **D/E register:**
  - Captures op_rs, op_rt, d_rs, d_rt and d_valid when !stall.
  - Captures a bubble (e_valid=0, values 0) when stall.
- **E-stage re-forward** for each source s held in D/E:
  - M match with M.tnew==0 selects m_fwd_data.
  - Otherwise, W match selects w_fwd_data.
  - Otherwise, the registered value.
- **Reset:**
  - All slots invalid; e_valid=0; e_rs_val=e_rt_val=0; stall_cnt=0.
  - Rst overrides stall and every capture in the same cycle.
  - Reset mid-stall drops the held instruction state inside this block; upstream refetches.

## Timing

- stall, op_rs, op_rt, rf_a1 and rf_a2 are combinational in the same cycle as the D inputs.
- e_rs_val and e_rt_val are registered plus a combinational re-forward mux.
- ALU producer (tnew=1) followed by a consumer with tuse=1:
  - Zero stalls.
  - The consumer takes m_fwd_data in E.
- ALU producer followed by a branch with tuse=0:
  - One stall.
  - Forwarded from M in D.
- Load (tnew=2) followed by a consumer with tuse=1:
  - One stall.
  - Then w_fwd_data in E.
- Load followed by a consumer with tuse=0:
  - Two stalls.
  - Then rf_rd.
- stall is never asserted while d_valid=0.

## Configuration

- OPFETCH_STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every posedge where stall=1 and Rst=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Clears on Rst.
- OPFETCH_STALL_CNT_EN undefined:
  - No counter logic.
  - stall_cnt is constant 0.

## Test plan

- **Reset:** Rst=1 for 2 cycles with d_valid=1 and d_rs=5 -> e_valid=0, e_rs_val=0, stall_cnt=0. No slot matches in the first cycle after reset.
- **ALU to ALU:** producer writes $8 (tnew=1); next instruction reads $8 (tuse=1); m_fwd_data=0x1234 -> stall=0, e_rs_val=0x1234 in the consumer's E cycle.
- **ALU to branch:**
  - Producer writes $9 (tnew=1); branch reads $9 (tuse=0).
  - Expected: stall=1 for exactly 1 cycle.
  - Next cycle: op_rs = m_fwd_data = 0xA5A5A5A5, stall=0.
- **Load-use:**
  - Load to $10 (tnew=2); consumer reads $10 (tuse=1).
  - Expected: 1 stall cycle and one bubble (e_valid=0).
  - The consumer's E cycle gives e_rs_val = w_fwd_data = 0xDEADBEEF.
- **Register 0 and priority:**
  - Producer writes $0 (tnew=2); next instruction reads $0 -> stall=0, op_rs=rf_rd1.
  - Separate check: E and M both write $3, both with tnew=0 -> op_rs=e_fwd_data.
- **Counter:** with OPFETCH_STALL_CNT_EN, run a load-use followed by a load-to-branch -> stall_cnt=3. Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Decode-stage operand reader and hazard controller for the five-stage
// pipeline. Reads the register file, picks each D-stage operand from the
// register file or the E/M result buses, and tracks the destinations of the
// instructions in E, M and W in three shadow slots. D is stalled when a
// producer result cannot reach its consumer in time. The block also holds
// the D/E operand register and re-forwards the held operands from M or W.
//
// Optional feature macro: OPFETCH_STALL_CNT_EN
//   defined   -> stall_cnt counts stall cycles (wraps, cleared by Rst)
//   undefined -> stall_cnt is tied to 0 and no counter logic is built
//
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   d_valid                  instruction present in D
//   d_rs, d_rt               source register numbers
//   d_use_rs, d_use_rt       source actually read
//   d_tuse_rs, d_tuse_rt     cycles after D until the operand is consumed
//   d_dst, d_wen, d_tnew     destination, write enable, cycles until ready
//   rf_a1, rf_a2             register file read addresses
//   rf_rd1, rf_rd2           register file read data
//   e_fwd_data ... w_fwd_data stage result buses
//   stall                    hold D/F, inject a bubble into E
//   op_rs, op_rt             forwarded D-stage operands
//   e_valid                  D/E register valid
//   e_rs_val, e_rt_val       forwarded E-stage operands
//   stall_cnt                stall cycle counter
// ---------------------------------------------------------------------------
module operand_fetch (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        d_valid,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_dst,
    input  logic        d_wen,
    input  logic [1:0]  d_tnew,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic [31:0] e_fwd_data,
    input  logic [31:0] m_fwd_data,
    input  logic [31:0] w_fwd_data,
    output logic        stall,
    output logic [31:0] op_rs,
    output logic [31:0] op_rt,
    output logic        e_valid,
    output logic [31:0] e_rs_val,
    output logic [31:0] e_rt_val,
    output logic [31:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       wen;
        logic [1:0] tnew;
    } slot_t;

    slot_t       slot_e;
    slot_t       slot_m;
    slot_t       slot_w;

    logic [4:0]  e_rs_num;
    logic [4:0]  e_rt_num;
    logic [31:0] e_rs_reg;
    logic [31:0] e_rt_reg;

    logic        hazard_rs;
    logic        hazard_rt;

    // Register 0 is hard-wired, so it never takes part in matching.
    function automatic logic slot_match(input slot_t sl, input logic [4:0] src);
        return sl.valid && sl.wen && (sl.dst == src) && (src != 5'd0);
    endfunction

    // W is never a D-stage hazard: its result is already readable by then.
    function automatic logic src_hazard(input slot_t      sl_e,
                                        input slot_t      sl_m,
                                        input logic       use_src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] src);
        logic e_late;
        logic m_late;
        e_late = slot_match(sl_e, src) && (sl_e.tnew > tuse);
        m_late = slot_match(sl_m, src) && (sl_m.tnew > tuse);
        return use_src && (e_late || m_late);
    endfunction

    // Youngest ready producer wins. No W bypass: the register file writes
    // on negedge, so a W result already shows up on rf_rd.
    function automatic logic [31:0] d_select(input slot_t       sl_e,
                                             input slot_t       sl_m,
                                             input logic [4:0]  src,
                                             input logic [31:0] rf_val,
                                             input logic [31:0] e_val,
                                             input logic [31:0] m_val);
        logic [31:0] sel;
        sel = rf_val;
        if (slot_match(sl_e, src) && (sl_e.tnew == 2'd0)) begin
            sel = e_val;
        end else if (slot_match(sl_m, src) && (sl_m.tnew == 2'd0)) begin
            sel = m_val;
        end
        return sel;
    endfunction

    // Fixes up operands captured in D while their producer was not ready yet.
    function automatic logic [31:0] e_select(input slot_t       sl_m,
                                             input slot_t       sl_w,
                                             input logic [4:0]  src,
                                             input logic [31:0] held,
                                             input logic [31:0] m_val,
                                             input logic [31:0] w_val);
        logic [31:0] sel;
        sel = held;
        if (slot_match(sl_m, src) && (sl_m.tnew == 2'd0)) begin
            sel = m_val;
        end else if (slot_match(sl_w, src)) begin
            sel = w_val;
        end
        return sel;
    endfunction

    function automatic slot_t age_slot(input slot_t sl);
        slot_t aged;
        aged = sl;
        if (sl.tnew != 2'd0) begin
            aged.tnew = sl.tnew - 2'd1;
        end
        return aged;
    endfunction

    assign rf_a1 = d_rs;
    assign rf_a2 = d_rt;

    always_comb begin
        hazard_rs = src_hazard(slot_e, slot_m, d_use_rs, d_tuse_rs, d_rs);
        hazard_rt = src_hazard(slot_e, slot_m, d_use_rt, d_tuse_rt, d_rt);
        stall     = d_valid && (hazard_rs || hazard_rt);
    end

    always_comb begin
        op_rs = d_select(slot_e, slot_m, d_rs, rf_rd1, e_fwd_data, m_fwd_data);
        op_rt = d_select(slot_e, slot_m, d_rt, rf_rd2, e_fwd_data, m_fwd_data);
    end

    always_comb begin
        e_rs_val = e_select(slot_m, slot_w, e_rs_num, e_rs_reg, m_fwd_data, w_fwd_data);
        e_rt_val = e_select(slot_m, slot_w, e_rt_num, e_rt_reg, m_fwd_data, w_fwd_data);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            slot_e   <= '0;
            slot_m   <= '0;
            slot_w   <= '0;
            e_valid  <= 1'b0;
            e_rs_num <= '0;
            e_rt_num <= '0;
            e_rs_reg <= '0;
            e_rt_reg <= '0;
        end else begin
            slot_w <= slot_m;
            slot_m <= age_slot(slot_e);
            if (stall) begin
                slot_e   <= '0;
                e_valid  <= 1'b0;
                e_rs_num <= '0;
                e_rt_num <= '0;
                e_rs_reg <= '0;
                e_rt_reg <= '0;
            end else begin
                slot_e   <= slot_t'{valid: d_valid, dst: d_dst, wen: d_wen, tnew: d_tnew};
                e_valid  <= d_valid;
                e_rs_num <= d_rs;
                e_rt_num <= d_rt;
                e_rs_reg <= op_rs;
                e_rt_reg <= op_rt;
            end
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
